data_mem_lat: RTL and testbench

//   Parametrised single-port data memory with a configurable access latency, replacing

---
 rtl/data_mem_lat.sv | 160 ++++++++++++++++
 tb/tb_data_mem_lat.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_lat.sv
// data_mem_lat: single-port data memory with a counter-based access latency.
// BUSY stalls the CPU while an access or the post-reset clear sweep is running;
// DONE pulses for one cycle when an access completes; CONFLICT flags a
// simultaneous read+write request that was refused.
module data_mem_lat #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned LATENCY        = 5,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              readEn,
  input  logic              writeEn,
  input  logic [ADDR_W-1:0] dataAddress,
  input  logic [DATA_W-1:0] dataIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              BUSY,
  output logic              DONE,
  output logic              CONFLICT
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CLEAR  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [1:0]        state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              clr_pend_q, clr_pend_d;
  logic              op_wr_q,    op_wr_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic [DATA_W-1:0] dout_q,     dout_d;
  logic              busy_q,     busy_d;
  logic              done_q,     done_d;
  logic              conflict_q, conflict_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Next-state, output and array-write decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_addr_d = clr_addr_q;
    clr_pend_d = clr_pend_q;
    op_wr_d    = op_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    dout_d     = dout_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    conflict_d = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = addr_q;
    mem_wdata  = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (clr_pend_q) begin
          // First edge out of reset starts the sweep; requests here are dropped
          state_d    = S_CLEAR;
          clr_pend_d = 1'b0;
          clr_addr_d = '0;
          busy_d     = 1'b1;
        end else if (readEn && writeEn) begin
          conflict_d = 1'b1;
        end else if (readEn || writeEn) begin
          op_wr_d = writeEn;
          addr_d  = dataAddress;
          wdata_d = dataIn;
          cnt_d   = CNT_W'(LATENCY - 1);
          busy_d  = 1'b1;
          state_d = S_ACCESS;
        end
      end

      S_CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_addr_q;
        mem_wdata = '0;
        if (clr_addr_q == '1) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end

      S_ACCESS: begin
        if (cnt_q == '0) begin
          if (op_wr_q) begin
            mem_we = 1'b1;
          end else begin
            dout_d = mem_q[addr_q];
          end
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and output registers; reset aborts any in-flight access
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      clr_addr_q <= '0;
      clr_pend_q <= 1'(CLEAR_ON_RESET != 0);
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      dout_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_addr_q <= clr_addr_d;
      clr_pend_q <= clr_pend_d;
      op_wr_q    <= op_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      dout_q     <= dout_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      conflict_q <= conflict_d;
    end
  end

  // Storage array; no write happens on a reset edge
  always_ff @(posedge CLK) begin
    if (mem_we && !RESET) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign dataOut  = dout_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign CONFLICT = conflict_q;

endmodule

// File: tb/tb_data_mem_lat.sv
// Bench for data_mem_lat: three instances with different geometries/latencies,
// directed stimulus, scoreboard of expected dataOut values popped on DONE.
module tb_data_mem_lat;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]       rst;
  logic [2:0]       re;
  logic [2:0]       we;
  logic [2:0][3:0]  addr;
  logic [2:0][15:0] din;
  wire  [2:0][15:0] dout;
  wire  [2:0]       busy;
  wire  [2:0]       done;
  wire  [2:0]       confl;

  // dut0: 8b data, latency 5; dut1: 8b data, latency 3; dut2: 16b data, latency 1
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned DW  = (g == 2) ? 16 : 8;
    localparam int unsigned LAT = (g == 0) ? 5 : ((g == 1) ? 3 : 1);
    logic [DW-1:0] dout_w;
    data_mem_lat #(
      .DATA_W(DW), .ADDR_W(4), .LATENCY(LAT), .CLEAR_ON_RESET(1)
    ) u_dut (
      .CLK(clk), .RESET(rst[g]), .readEn(re[g]), .writeEn(we[g]),
      .dataAddress(addr[g]), .dataIn(din[g][DW-1:0]), .dataOut(dout_w),
      .BUSY(busy[g]), .DONE(done[g]), .CONFLICT(confl[g])
    );
    assign dout[g] = 16'(dout_w);
  end

  typedef struct {
    int          g;
    logic [15:0] d;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] last_rd [3];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every DONE pops one expectation and compares dataOut
  always @(negedge clk) begin
    exp_t e;
    for (int g = 0; g < 3; g++) begin
      if (done[g] === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: dut%0d pulsed DONE with no access expected", g);
        end else begin
          e = sb.pop_front();
          check($sformatf("done_owner dut%0d", g), 16'(g), 16'(e.g));
          check($sformatf("dataOut dut%0d", g), dout[g], e.d);
        end
      end
    end
  end

  // Release reset at the current negedge, check reset values, time the clear sweep
  task automatic release_and_clear(input int g);
    int n;
    rst[g] = 1'b0;
    check($sformatf("rst_busy dut%0d", g), 16'(busy[g]), 16'd0);
    check($sformatf("rst_done dut%0d", g), 16'(done[g]), 16'd0);
    check($sformatf("rst_conflict dut%0d", g), 16'(confl[g]), 16'd0);
    check($sformatf("rst_dout dut%0d", g), dout[g], 16'd0);
    last_rd[g] = 16'd0;
    n = 0;
    @(negedge clk);
    while (busy[g] === 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check($sformatf("clear_busy_len dut%0d", g), 16'(n), 16'd16);
  endtask

  task automatic reset_clear(input int g);
    @(negedge clk);
    rst[g] = 1'b1;
    @(negedge clk);
    release_and_clear(g);
  endtask

  // One access; expected dataOut pushed before issue, busy length checked here
  task automatic access(input int g, input bit wr, input logic [3:0] a,
                        input logic [15:0] d, input int lat, input logic [15:0] exp_rd);
    exp_t e;
    int   n;
    e.g = g;
    e.d = wr ? last_rd[g] : exp_rd;
    sb.push_back(e);
    if (!wr) last_rd[g] = exp_rd;
    @(negedge clk);
    re[g]   = !wr;
    we[g]   = wr;
    addr[g] = a;
    din[g]  = d;
    @(posedge clk);
    #1;
    re[g] = 1'b0;
    we[g] = 1'b0;
    n = 0;
    @(negedge clk);
    while (busy[g] === 1'b1 && n < 100) begin
      n++;
      if (wr) check($sformatf("dout_hold_on_write dut%0d", g), dout[g], last_rd[g]);
      @(negedge clk);
    end
    check($sformatf("busy_len dut%0d", g), 16'(n), 16'(lat));
    check($sformatf("done_after_busy dut%0d", g), 16'(done[g]), 16'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int cnt;
    int prev;
    exp_t e;
    rst  = 3'b111;
    re   = '0;
    we   = '0;
    addr = '0;
    din  = '0;
    repeat (3) @(posedge clk);

    // T1: reset + 16-cycle clear on each instance, then read top address
    reset_clear(0);
    reset_clear(1);
    reset_clear(2);
    access(0, 1'b0, 4'hF, 16'h0, 5, 16'h0000);

    // T2: write/read pair, latency 5
    access(0, 1'b1, 4'h0, 16'h0A, 5, 16'h0);
    access(0, 1'b1, 4'h1, 16'h0B, 5, 16'h0);
    access(0, 1'b0, 4'h0, 16'h0, 5, 16'h000A);
    access(0, 1'b0, 4'h1, 16'h0, 5, 16'h000B);

    // T4: both enables high in IDLE
    @(negedge clk);
    re[0] = 1'b1; we[0] = 1'b1; addr[0] = 4'h0; din[0] = 16'hFF;
    @(posedge clk);
    #1;
    re[0] = 1'b0; we[0] = 1'b0;
    @(negedge clk);
    check("conflict_pulse", 16'(confl[0]), 16'd1);
    check("conflict_busy", 16'(busy[0]), 16'd0);
    check("conflict_dout", dout[0], 16'h000B);
    @(negedge clk);
    check("conflict_one_cycle", 16'(confl[0]), 16'd0);
    access(0, 1'b0, 4'h0, 16'h0, 5, 16'h000A);

    // T3: read held high 20 cycles at latency 3
    access(1, 1'b1, 4'h5, 16'h3C, 3, 16'h0);
    e.g = 1;
    e.d = 16'h003C;
    for (int k = 0; k < 5; k++) sb.push_back(e);
    last_rd[1] = 16'h003C;
    @(negedge clk);
    re[1] = 1'b1;
    addr[1] = 4'h5;
    cnt = 0;
    prev = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done[1] === 1'b1) begin
        cnt++;
        if (prev >= 0) check("held_done_spacing", 16'(i - prev), 16'd4);
        prev = i;
      end
    end
    re[1] = 1'b0;
    check("held_done_count", 16'(cnt), 16'd5);
    @(negedge clk);
    check("held_idle_after", 16'(busy[1]), 16'd0);

    // T5: reset on the second busy cycle of a write of 8'h55 to address 3
    @(negedge clk);
    we[0] = 1'b1; addr[0] = 4'h3; din[0] = 16'h55;
    @(posedge clk);
    #1;
    we[0] = 1'b0;
    @(negedge clk);
    check("t5_busy_cycle1", 16'(busy[0]), 16'd1);
    @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    release_and_clear(0);
    access(0, 1'b0, 4'h3, 16'h0, 5, 16'h0000);

    // T6: latency 1, 16-bit data, top address
    access(2, 1'b1, 4'h2, 16'h1234, 1, 16'h0);
    access(2, 1'b0, 4'h2, 16'h0, 1, 16'h1234);
    access(2, 1'b1, 4'hF, 16'hBEEF, 1, 16'h0);
    access(2, 1'b0, 4'hF, 16'h0, 1, 16'hBEEF);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
